mem_port_arbiter: RTL and testbench

- Shares the single memory port between the IF-stage instruction requester and the EX-stage data requester (the req/we/addr/wdata bundle EX drives on its data bus).
- Uses a req/addr_ok/data_ok split-transaction handshake. Tracks outstanding transactions in order and steers each data_ok/rdata back to the requester that owns it.
- Sits between the pipeline front/back ends and the memory interface. Default policy gives data fixed priority over instruction.

---
 rtl/mem_port_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one split-transaction memory port between the
// IF-stage fetch requester and the EX-stage load/store requester.
// Accepted transactions are tracked in an in-order owner FIFO so every
// data_ok/rdata is steered back to the requester that issued it.
// Build option: define ARB_RR_EN for round-robin grant between the two
// requesters; otherwise data always wins over instruction.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch side
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic              inst_addr_ok_o,
    output logic              inst_data_ok_o,
    output logic [DATA_W-1:0] inst_rdata_o,
    // load/store side
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_addr_ok_o,
    output logic              data_data_ok_o,
    output logic [DATA_W-1:0] data_rdata_o,
    // memory side
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_addr_ok_i,
    input  logic              mem_data_ok_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    // status
    output logic              busy_o
);

    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    // Owner ids stored in the FIFO and the lock/last-grant registers.
    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]     count_q,      count_d;
    logic [PTR_W-1:0]     wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q,     rd_ptr_d;
    logic [MAX_OUTST-1:0] owner_q,      owner_d;
    logic                 lock_q,       lock_d;
    logic                 lock_owner_q, lock_owner_d;
`ifdef ARB_RR_EN
    logic                 last_grant_q, last_grant_d;
`endif

    // ------------------------------------------------------------------
    // Internal combinational signals
    // ------------------------------------------------------------------
    logic full;
    logic empty;
    logic gnt_valid;
    logic gnt_owner;
    logic accept;
    logic pop;
    logic head_owner;

    assign full       = (count_q == CNT_W'(MAX_OUTST));
    assign empty      = (count_q == '0);
    assign head_owner = owner_q[rd_ptr_q];

    // Grant selection: lock holds the stalled owner, otherwise priority/RR.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_owner = OWNER_INST;
        if (rst_n && !full) begin
            if (lock_q) begin
                gnt_owner = lock_owner_q;
                gnt_valid = lock_owner_q ? data_req_i : inst_req_i;
            end else if (data_req_i && inst_req_i) begin
                gnt_valid = 1'b1;
`ifdef ARB_RR_EN
                gnt_owner = ~last_grant_q;
`else
                gnt_owner = OWNER_DATA;
`endif
            end else if (data_req_i) begin
                gnt_valid = 1'b1;
                gnt_owner = OWNER_DATA;
            end else if (inst_req_i) begin
                gnt_valid = 1'b1;
                gnt_owner = OWNER_INST;
            end
        end
    end

    assign accept = gnt_valid & mem_addr_ok_i;
    assign pop    = rst_n & mem_data_ok_i & ~empty;

    // Request path: drive the memory port from the granted requester.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (gnt_valid) begin
            mem_req_o = 1'b1;
            if (gnt_owner == OWNER_DATA) begin
                mem_we_o    = data_we_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_addr_o  = inst_addr_i;
            end
        end
    end

    // Address handshake: zero-latency addr_ok back to the granted requester.
    always_comb begin
        inst_addr_ok_o = accept & (gnt_owner == OWNER_INST);
        data_addr_ok_o = accept & (gnt_owner == OWNER_DATA);
    end

    // Response path: route data_ok/rdata to the FIFO head owner.
    always_comb begin
        inst_data_ok_o = 1'b0;
        data_data_ok_o = 1'b0;
        inst_rdata_o   = '0;
        data_rdata_o   = '0;
        if (pop) begin
            if (head_owner == OWNER_DATA) begin
                data_data_ok_o = 1'b1;
                data_rdata_o   = mem_rdata_i;
            end else begin
                inst_data_ok_o = 1'b1;
                inst_rdata_o   = mem_rdata_i;
            end
        end
    end

    assign busy_o = rst_n & ~empty;

    // Next-state: owner FIFO, occupancy count, grant lock, last grant.
    always_comb begin
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        owner_d      = owner_q;
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
`ifdef ARB_RR_EN
        last_grant_d = last_grant_q;
`endif

        if (accept) begin
            owner_d[wr_ptr_q] = gnt_owner;
            wr_ptr_d          = PTR_W'(wr_ptr_q + PTR_W'(1));
        end
        if (pop) begin
            rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
        end

        case ({accept, pop})
            2'b10:   count_d = CNT_W'(count_q + CNT_W'(1));
            2'b01:   count_d = CNT_W'(count_q - CNT_W'(1));
            default: count_d = count_q;
        endcase

        // A stalled request pins the grant; cleared once the address is taken
        // (or if the requester withdraws, so the port can never wedge).
        lock_d       = gnt_valid & ~mem_addr_ok_i;
        lock_owner_d = gnt_owner;

`ifdef ARB_RR_EN
        if (accept) begin
            last_grant_d = gnt_owner;
        end
`endif
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            owner_q      <= '0;
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_INST;
`ifdef ARB_RR_EN
            last_grant_q <= OWNER_INST;
`endif
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            owner_q      <= owner_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
`ifdef ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (default parameters, MAX_OUTST=2).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        inst_req_i;
    logic [31:0] inst_addr_i;
    logic        inst_addr_ok_o;
    logic        inst_data_ok_o;
    logic [31:0] inst_rdata_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_addr_ok_o;
    logic        data_data_ok_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_addr_ok_i;
    logic        mem_data_ok_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mem_port_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_req_i     (inst_req_i),
        .inst_addr_i    (inst_addr_i),
        .inst_addr_ok_o (inst_addr_ok_o),
        .inst_data_ok_o (inst_data_ok_o),
        .inst_rdata_o   (inst_rdata_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_addr_ok_o (data_addr_ok_o),
        .data_data_ok_o (data_data_ok_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_addr_ok_i  (mem_addr_ok_i),
        .mem_data_ok_i  (mem_data_ok_i),
        .mem_rdata_i    (mem_rdata_i),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and return on the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic exp_own;
        logic prev_own;

        rst_n         = 1'b0;
        inst_req_i    = 1'b1;
        inst_addr_i   = 32'h1C00_0000;
        data_req_i    = 1'b0;
        data_we_i     = 1'b0;
        data_addr_i   = '0;
        data_wdata_i  = '0;
        mem_addr_ok_i = 1'b1;
        mem_data_ok_i = 1'b1;
        mem_rdata_i   = 32'hFFFF_FFFF;

        // Outputs held at 0 during reset even with active inputs.
        @(negedge clk); #1;
        chk("rst_mem_req",   32'(mem_req_o), 32'd0);
        chk("rst_addr_ok",   32'(inst_addr_ok_o), 32'd0);
        chk("rst_data_ok",   32'(inst_data_ok_o), 32'd0);
        chk("rst_mem_addr",  mem_addr_o, 32'd0);
        chk("rst_busy",      32'(busy_o), 32'd0);
        inst_req_i = 1'b0; mem_addr_ok_i = 1'b0; mem_data_ok_i = 1'b0; mem_rdata_i = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // ---- Single fetch ----
        inst_req_i = 1'b1; inst_addr_i = 32'h1C00_0000; mem_addr_ok_i = 1'b1; #1;
        chk("f_mem_req",     32'(mem_req_o), 32'd1);
        chk("f_mem_addr",    mem_addr_o, 32'h1C00_0000);
        chk("f_mem_we",      32'(mem_we_o), 32'd0);
        chk("f_inst_aok",    32'(inst_addr_ok_o), 32'd1);
        chk("f_data_aok",    32'(data_addr_ok_o), 32'd0);
        tick();
        inst_req_i = 1'b0; mem_addr_ok_i = 1'b0; #1;
        chk("f_busy",        32'(busy_o), 32'd1);
        chk("f_idle_req",    32'(mem_req_o), 32'd0);
        tick();
        mem_data_ok_i = 1'b1; mem_rdata_i = 32'h0280_0400; #1;
        chk("f_inst_dok",    32'(inst_data_ok_o), 32'd1);
        chk("f_inst_rdata",  inst_rdata_o, 32'h0280_0400);
        chk("f_data_dok",    32'(data_data_ok_o), 32'd0);
        chk("f_data_rdata",  data_rdata_o, 32'd0);
        tick();
        mem_data_ok_i = 1'b0; #1;
        chk("f_busy_end",    32'(busy_o), 32'd0);

        // ---- Simultaneous requests: data first, then inst ----
        inst_req_i = 1'b1; inst_addr_i = 32'h1C00_0004;
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h100; data_wdata_i = 32'hDEAD_BEEF;
        mem_addr_ok_i = 1'b1; #1;
        chk("s_we",          32'(mem_we_o), 32'd1);
        chk("s_addr",        mem_addr_o, 32'h100);
        chk("s_wdata",       mem_wdata_o, 32'hDEAD_BEEF);
        chk("s_data_aok",    32'(data_addr_ok_o), 32'd1);
        chk("s_inst_aok0",   32'(inst_addr_ok_o), 32'd0);
        tick();
        data_req_i = 1'b0; #1;
        chk("s_addr2",       mem_addr_o, 32'h1C00_0004);
        chk("s_we2",         32'(mem_we_o), 32'd0);
        chk("s_wdata2",      mem_wdata_o, 32'd0);
        chk("s_inst_aok",    32'(inst_addr_ok_o), 32'd1);
        tick();
        inst_req_i = 1'b0; mem_addr_ok_i = 1'b0;
        mem_data_ok_i = 1'b1; mem_rdata_i = 32'h1111_1111; #1;
        chk("s_r1_data_dok", 32'(data_data_ok_o), 32'd1);
        chk("s_r1_rdata",    data_rdata_o, 32'h1111_1111);
        chk("s_r1_inst_dok", 32'(inst_data_ok_o), 32'd0);
        chk("s_r1_inst_rd",  inst_rdata_o, 32'd0);
        tick();
        mem_rdata_i = 32'h2222_2222; #1;
        chk("s_r2_inst_dok", 32'(inst_data_ok_o), 32'd1);
        chk("s_r2_rdata",    inst_rdata_o, 32'h2222_2222);
        chk("s_r2_data_dok", 32'(data_data_ok_o), 32'd0);
        tick();
        mem_data_ok_i = 1'b0; #1;
        chk("s_busy_end",    32'(busy_o), 32'd0);

        // ---- Lock on a stalled data request ----
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h200; data_wdata_i = '0; #1;
        chk("ld_c1_addr",    mem_addr_o, 32'h200);
        tick();
        inst_req_i = 1'b1; inst_addr_i = 32'h1C00_0008; #1;
        chk("ld_c2_addr",    mem_addr_o, 32'h200);
        chk("ld_c2_daok",    32'(data_addr_ok_o), 32'd0);
        tick(); #1;
        chk("ld_c3_addr",    mem_addr_o, 32'h200);
        tick();
        mem_addr_ok_i = 1'b1; #1;
        chk("ld_c4_daok",    32'(data_addr_ok_o), 32'd1);
        chk("ld_c4_addr",    mem_addr_o, 32'h200);
        tick();
        data_req_i = 1'b0; #1;
        chk("ld_c5_iaok",    32'(inst_addr_ok_o), 32'd1);
        chk("ld_c5_addr",    mem_addr_o, 32'h1C00_0008);
        tick();
        inst_req_i = 1'b0; mem_addr_ok_i = 1'b0;
        mem_data_ok_i = 1'b1; mem_rdata_i = 32'h5A5A_0001; #1;
        chk("ld_r1_ddok",    32'(data_data_ok_o), 32'd1);
        tick();
        mem_rdata_i = 32'h5A5A_0002; #1;
        chk("ld_r2_idok",    32'(inst_data_ok_o), 32'd1);
        chk("ld_r2_rdata",   inst_rdata_o, 32'h5A5A_0002);
        tick();
        mem_data_ok_i = 1'b0;

        // ---- Lock on a stalled fetch: a later data request must wait ----
        inst_req_i = 1'b1; inst_addr_i = 32'h1C00_000C; #1;
        chk("li_c1_addr",    mem_addr_o, 32'h1C00_000C);
        tick();
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h300; data_wdata_i = 32'hCAFE_F00D; #1;
        chk("li_c2_addr",    mem_addr_o, 32'h1C00_000C);
        chk("li_c2_we",      32'(mem_we_o), 32'd0);
        tick();
        mem_addr_ok_i = 1'b1; #1;
        chk("li_c3_iaok",    32'(inst_addr_ok_o), 32'd1);
        chk("li_c3_daok",    32'(data_addr_ok_o), 32'd0);
        tick();
        inst_req_i = 1'b0; #1;
        chk("li_c4_daok",    32'(data_addr_ok_o), 32'd1);
        chk("li_c4_we",      32'(mem_we_o), 32'd1);
        chk("li_c4_wdata",   mem_wdata_o, 32'hCAFE_F00D);
        tick();
        data_req_i = 1'b0; data_we_i = 1'b0;

        // ---- Full: two outstanding (inst, data) ----
        inst_req_i = 1'b1; inst_addr_i = 32'h1C00_0010; #1;
        chk("full_req",      32'(mem_req_o), 32'd0);
        chk("full_iaok",     32'(inst_addr_ok_o), 32'd0);
        chk("full_addr",     mem_addr_o, 32'd0);
        tick();
        mem_data_ok_i = 1'b1; mem_rdata_i = 32'h3333_3333; #1;
        chk("full_pop_idok", 32'(inst_data_ok_o), 32'd1);
        chk("full_pop_req",  32'(mem_req_o), 32'd0);
        tick();
        mem_rdata_i = 32'h4444_4444; #1;
        chk("pp_req",        32'(mem_req_o), 32'd1);
        chk("pp_iaok",       32'(inst_addr_ok_o), 32'd1);
        chk("pp_ddok",       32'(data_data_ok_o), 32'd1);
        chk("pp_rdata",      data_rdata_o, 32'h4444_4444);
        chk("pp_idok",       32'(inst_data_ok_o), 32'd0);
        tick();
        mem_data_ok_i = 1'b0; inst_addr_i = 32'h1C00_0014; #1;
        chk("refill_iaok",   32'(inst_addr_ok_o), 32'd1);
        tick(); #1;
        chk("refull_req",    32'(mem_req_o), 32'd0);
        inst_req_i = 1'b0;

        // ---- Reset with outstanding entries ----
        mem_data_ok_i = 1'b1; mem_rdata_i = 32'h5555_5555; #1;
        chk("pre_rst_idok",  32'(inst_data_ok_o), 32'd1);
        tick();
        mem_data_ok_i = 1'b0; #1;
        chk("pre_rst_busy",  32'(busy_o), 32'd1);
        rst_n = 1'b0; #1;
        chk("rst_busy0",     32'(busy_o), 32'd0);
        tick();
        rst_n = 1'b1; mem_data_ok_i = 1'b1; mem_rdata_i = 32'h6666_6666; #1;
        chk("late_idok",     32'(inst_data_ok_o), 32'd0);
        chk("late_ddok",     32'(data_data_ok_o), 32'd0);
        chk("late_rdata",    inst_rdata_o, 32'd0);
        tick(); #1;
        chk("spur_idok",     32'(inst_data_ok_o), 32'd0);
        chk("spur_busy",     32'(busy_o), 32'd0);

        // ---- Both requesters continuously asserting, memory always ready ----
        inst_req_i = 1'b1; inst_addr_i = 32'h1C00_0020;
        data_req_i = 1'b1; data_addr_i = 32'h400;
        mem_addr_ok_i = 1'b1; mem_rdata_i = 32'h7777_7777;
        prev_own = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_own = RR ? ((i % 2) == 0) : 1'b1;
            #1;
            chk($sformatf("bb_addr%0d", i), mem_addr_o, exp_own ? 32'h400 : 32'h1C00_0020);
            chk($sformatf("bb_daok%0d", i), 32'(data_addr_ok_o), 32'(exp_own));
            if (i > 0) begin
                chk($sformatf("bb_ddok%0d", i), 32'(data_data_ok_o), 32'(prev_own));
                chk($sformatf("bb_idok%0d", i), 32'(inst_data_ok_o), 32'(!prev_own));
            end
            prev_own = exp_own;
            tick();
        end
        inst_req_i = 1'b0; data_req_i = 1'b0; mem_addr_ok_i = 1'b0; #1;
        chk("bb_last_ddok",  32'(data_data_ok_o), 32'(prev_own));
        tick();
        mem_data_ok_i = 1'b0; #1;
        chk("bb_busy_end",   32'(busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
